// File: rtl/alu_add.sv
// Signed 16-bit saturating adder with combinational Z/V/N flags and a
// condition-code register that loads only on flag-setting operations.
module alu_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        flag_en,
    output logic [15:0] result,
    output logic        ovfl,
    output logic        zero,
    output logic        sign,
    output logic [2:0]  flags_q
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [15:0] bit_carry;
    logic [15:0] sum_raw;
    logic [3:0]  grp_carry;
    logic [2:0]  flags_reg;

    assign gen          = a & b;
    assign prop         = a ^ b;
    assign grp_carry[0] = 1'b0;

    // Four 4-bit lookahead groups; the group carry ripples into the next group.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cla
            logic [3:0] g;
            logic [3:0] p;
            logic       ci;

            assign g  = gen[4*gi +: 4];
            assign p  = prop[4*gi +: 4];
            assign ci = grp_carry[gi];

            assign bit_carry[4*gi]     = ci;
            assign bit_carry[4*gi + 1] = g[0] | (p[0] & ci);
            assign bit_carry[4*gi + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
            assign bit_carry[4*gi + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                                       | (p[2] & p[1] & p[0] & ci);

            // The top group's carry-out is not needed: overflow comes from sign bits.
            if (gi < 3) begin : g_ripple
                assign grp_carry[gi + 1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                                         | (p[3] & p[2] & p[1] & g[0])
                                         | (p[3] & p[2] & p[1] & p[0] & ci);
            end
        end
    endgenerate

    assign sum_raw = prop ^ bit_carry;
    assign ovfl    = (a[15] == b[15]) && (sum_raw[15] != a[15]);

    // On overflow both operands share a sign, so a[15] selects the clamp direction.
    always_comb begin
        result = sum_raw;
        if (ovfl) begin
            result = a[15] ? 16'h8000 : 16'h7FFF;
        end
    end

    assign zero = (result == 16'h0000);
    assign sign = result[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= 3'b000;
        end else if (flag_en) begin
            flags_reg <= {zero, ovfl, sign};
        end
    end

    assign flags_q = flags_reg;

endmodule

// File: tb/tb_alu_add.sv
// Self-checking bench for alu_add: directed saturation cases, flag register
// behaviour around reset, and randomized comparison against an exact-sum model.
module tb_alu_add;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        flag_en;
    logic [15:0] result;
    logic        ovfl;
    logic        zero;
    logic        sign;
    logic [2:0]  flags_q;

    int checks;
    int failures;

    alu_add dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .flag_en (flag_en),
        .result  (result),
        .ovfl    (ovfl),
        .zero    (zero),
        .sign    (sign),
        .flags_q (flags_q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // Exact integer sum clamped to the signed 16-bit range.
    // Returns {result[15:0], ovfl, zero, sign}.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
        int s;
        int c;
        s = int'($signed(x)) + int'($signed(y));
        if (s > 32767)       c = 32767;
        else if (s < -32768) c = -32768;
        else                 c = s;
        model = {c[15:0], (s != c), (c == 0), (c < 0)};
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        flag_en = 1'b1;
        a       = 16'h7FFF;
        b       = 16'h0001;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (flags_q !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000", flags_q);
        end
        checks++;
        if (result !== 16'h7FFF || ovfl !== 1'b1) begin
            failures++;
            $display("FAIL reset_comb: got result=%h ovfl=%b required result=7fff ovfl=1", result, ovfl);
        end
        $display("test_reset: flags_q=%b result=%h", flags_q, result);
        @(negedge clk);
        flag_en = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [10] = '{16'h7FFF, 16'h8000, 16'h0005, 16'h0000, 16'h0064,
                                 16'hFED4, 16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF};
        logic [15:0] tb [10] = '{16'h0001, 16'hFFFF, 16'hFFFB, 16'h0000, 16'h0017,
                                 16'h002C, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001};
        logic [15:0] tr [10] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h007B,
                                 16'hFF00, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        logic [2:0]  tf [10] = '{3'b100, 3'b101, 3'b010, 3'b010, 3'b000,
                                 3'b001, 3'b101, 3'b100, 3'b001, 3'b010}; // {ovfl,zero,sign}
        for (int i = 0; i < 10; i++) begin
            a = ta[i];
            b = tb[i];
            #10;
            checks++;
            if (result !== tr[i]) begin
                failures++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, result, tr[i]);
            end
            checks++;
            if ({ovfl, zero, sign} !== tf[i]) begin
                failures++;
                $display("FAIL directed_flags[%0d]: got ovfl/zero/sign=%b required %b",
                         i, {ovfl, zero, sign}, tf[i]);
            end
            $display("directed %0d: a=%h b=%h result=%h vzn=%b", i, a, b, result, {ovfl, zero, sign});
        end
    endtask

    task automatic test_flag_register();
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; flag_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 3'b010) begin
            failures++;
            $display("FAIL flag_load_pos_sat: got %b required 010", flags_q);
        end
        $display("flag load 7fff+1: flags_q=%b", flags_q);

        @(negedge clk);
        a = 16'h0005; b = 16'hFFFB; flag_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 3'b010) begin
            failures++;
            $display("FAIL flag_hold: got %b required 010", flags_q);
        end
        $display("flag hold 5+-5: flags_q=%b", flags_q);

        @(negedge clk);
        flag_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 3'b100) begin
            failures++;
            $display("FAIL flag_load_zero: got %b required 100", flags_q);
        end
        $display("flag load 5+-5: flags_q=%b", flags_q);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 16'h8000; b = 16'hFFFF; flag_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 3'b011) begin
            failures++;
            $display("FAIL flag_load_neg_sat: got %b required 011", flags_q);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flags_q !== 3'b000) begin
            failures++;
            $display("FAIL async_reset: got %b required 000", flags_q);
        end
        checks++;
        if (result !== 16'h8000 || sign !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_comb: got result=%h sign=%b required 8000 1", result, sign);
        end
        $display("async reset: flags_q=%b result=%h", flags_q, result);
        @(negedge clk);
        flag_en = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (flags_q !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_hold: got %b required 000", flags_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  exp_flags;
        logic [18:0] m;
        logic [31:0] r;
        exp_flags = flags_q === 3'b000 ? 3'b000 : 3'bxxx;
        exp_flags = 3'b000;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r = $urandom; a = r[15:0];
            r = $urandom; b = r[15:0];
            r = $urandom; flag_en = r[0];
            m = model(a, b);
            if (flag_en) exp_flags = {m[1], m[2], m[0]};
            @(posedge clk); #1;
            checks++;
            if (flags_q !== exp_flags) begin
                failures++;
                $display("FAIL b2b_flags[%0d]: a=%h b=%h en=%b got %b required %b",
                         i, a, b, flag_en, flags_q, exp_flags);
            end
            $display("b2b %0d: a=%h b=%h en=%b flags_q=%b", i, a, b, flag_en, flags_q);
        end
        @(negedge clk);
        flag_en = 1'b0;
    endtask

    task automatic test_random();
        logic [18:0] m;
        logic [31:0] r;
        bit          bad;
        bad = 1'b0;
        for (int i = 0; i < 10000 && !bad; i++) begin
            r = $urandom; a = r[15:0];
            r = $urandom; b = r[15:0];
            #10;
            m = model(a, b);
            checks++;
            if ({result, ovfl, zero, sign} !== m) begin
                failures++;
                bad = 1'b1;
                $display("FAIL random[%0d]: a=%h b=%h got res=%h vzn=%b required res=%h vzn=%b",
                         i, a, b, result, {ovfl, zero, sign}, m[18:3], m[2:0]);
            end
            $display("random %0d: a=%h b=%h result=%h vzn=%b", i, a, b, result, {ovfl, zero, sign});
        end
        if (!bad) $display("Success");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flag_en  = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        test_reset();
        test_directed();
        test_flag_register();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_add.md
# alu_add

Signed 16-bit saturating adder for the RISC processor ALU datapath. It produces a combinational clamped sum and its overflow, zero and sign flags. It also holds a registered copy of those flags for the condition-code logic; the register updates only when the ALU executes a flag-setting ADD. All outputs except the flag register are purely combinational from `a` and `b`.

## Interface
- No parameters; datapath width fixed at 16 bits.
- `clk`  input  1  system clock; flag register samples on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; clears flag register.
- `a`  input  16  first operand, two's complement signed.
- `b`  input  16  second operand, two's complement signed.
- `flag_en`  input  1  when high at a rising `clk` edge, the current flags are loaded into `flags_q`.
- `result`  output  16  saturated signed sum, combinational.
- `ovfl`  output  1  signed overflow of the true sum, combinational.
- `zero`  output  1  `result` == 0, combinational.
- `sign`  output  1  `result[15]`, combinational.
- `flags_q`  output  3  registered flags {zero, ovfl, sign} (bit 2 = Z, bit 1 = V, bit 0 = N).
- One clock; reset is asynchronous and active-low.

## Operation
- Raw sum: `s = a + b` computed on 16 bits. Use four 4-bit carry-lookahead groups with ripple between groups. Carry-in is 0.
- Overflow detect: `ovfl = (a[15] == b[15]) && (s[15] != a[15])`.
- Saturation:
  - Positive overflow (`a[15]=0`, `b[15]=0`, `ovfl=1`) -> `result = 16'h7FFF`.
  - Negative overflow (`a[15]=1`, `b[15]=1`, `ovfl=1`) -> `result = 16'h8000`.
  - Otherwise `result = s`.
- `result` is always equal to the mathematically exact `a+b` clamped to [-32768, 32767].
- `zero` is evaluated on the saturated `result`. It can never be 1 when `ovfl=1`.
- `sign` is evaluated on the saturated `result`. Under overflow it therefore equals the sign of the true sum.
- Flag register:
  - On rising `clk` with `rst_n=1` and `flag_en=1`: `flags_q <= {zero, ovfl, sign}`.
  - With `flag_en=0`: `flags_q` holds its value.
- No X propagation: every output is defined for every 0/1 input combination.

## Timing
- `result`, `ovfl`, `zero`, `sign`:
  - Zero-cycle latency; combinational from `a`/`b`.
  - Independent of `clk` and `rst_n`, including during reset.
  - Settled within one clock period; bench samples 10 time units after input change.
- `flags_q`:
  - Reset value 3'b000, asserted immediately when `rst_n` falls, with no clock required.
  - Held at 0 while `rst_n=0` regardless of `flag_en`.
  - First load occurs at the first rising edge after `rst_n` deasserts with `flag_en=1`.
  - Reflects the flags of operands present at that edge; one-cycle latency relative to the combinational flags.
- Reset asserted mid-operation clears `flags_q` asynchronously; combinational outputs are unaffected.
- `flag_en` and operand changes at the same edge: the register captures the pre-edge combinational values.

## Test plan
- Positive saturation: `a=16'h7FFF`, `b=16'h0001` -> `result=16'h7FFF`, `ovfl=1`, `zero=0`, `sign=0`.
- Negative saturation: `a=16'h8000`, `b=16'hFFFF` -> `result=16'h8000`, `ovfl=1`, `zero=0`, `sign=1`.
- Zero result: `a=5`, `b=-5` -> `result=0`, `zero=1`, `ovfl=0`, `sign=0`. Also `a=0`, `b=0` gives the same response.
- Normal adds: `a=100`, `b=23` -> `result=123`, all flags 0. `a=-300`, `b=44` -> `result=-256`, `sign=1`, other flags 0.
- Flag register:
  - Hold `rst_n=0` -> `flags_q=000`.
  - Release reset and apply `7FFF+1` with `flag_en=1` -> after edge `flags_q=010`.
  - Apply `5+(-5)` with `flag_en=0` -> `flags_q` stays 010.
  - Pulse `rst_n=0` between edges -> `flags_q=000` immediately.
- Random regression: 10000 `$random` operand pairs.
  - Compare `result` against a 17-bit exact sum clamped to [-32768, 32767].
  - Check `ovfl`, `zero`, `sign` against the same model.
  - Stop at the first mismatch and report the index; otherwise print "Success".
